// File: rtl/mem_read_arbiter_pkg.sv
// mem_read_arbiter_pkg
// Shared types and constants for the memory read-port arbiter:
//   arb_state_t  - arbiter FSM state (IDLE / ADDR / DATA), 2-bit encoding
//   GNT_IFU/LSU  - encoding of the 1-bit grant (and round-robin 'last') register
//   RESP_*       - AXI read response codes (passed through, never interpreted)
package mem_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/mem_read_arbiter_arb_pick.sv
// arb_pick
// Combinational winner selection between the IFU and LSU read requests.
// Build option: ARB_ROUND_ROBIN_EN
//   defined   - on a tie the master not recorded in 'last' wins
//   undefined - fixed priority, LSU always beats IFU; 'last' is ignored
// Ports:
//   ifu_req  in   IFU arvalid
//   lsu_req  in   LSU arvalid
//   last     in   master that completed most recently (GNT_* encoding)
//   req_any  out  at least one request pending
//   winner   out  selected master (GNT_* encoding), valid when req_any
module arb_pick
  import mem_read_arbiter_pkg::*;
(
  input  logic ifu_req,
  input  logic lsu_req,
  input  logic last,
  output logic req_any,
  output logic winner
);

  assign req_any = ifu_req | lsu_req;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = GNT_IFU;
    if (ifu_req && lsu_req) winner = ~last;
    else if (lsu_req)       winner = GNT_LSU;
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    winner = GNT_IFU;
    if (lsu_req) winner = GNT_LSU;
  end
`endif

endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
// Shares the single AXI-lite read port of data memory between the IFU and the
// LSU load path. One transaction outstanding at a time, granted whole: the
// winner's address is registered onto the memory AR channel and the R
// response is routed back to the same master.
// Build option: ARB_ROUND_ROBIN_EN (round-robin tie break; default fixed
// priority with LSU over IFU).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ifu_ar*/ifu_r*              IFU read address / response channels
//   lsu_ar*/lsu_r*              LSU read address / response channels
//   mem_ar*/mem_r*              memory read address / response channels
//
// state | meaning
// IDLE  | no transaction; arbitrate, pulse winner's arready, latch address
// ADDR  | mem_arvalid held with stable mem_araddr until mem_arready
// DATA  | R channel routed to the granted master until the R handshake
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_arready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  input  logic              ifu_rready,

  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_arready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  input  logic              lsu_rready,

  output logic              mem_arvalid,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              mem_rready
);

  arb_state_t state;
  logic       grant;
  logic       last_q;
  logic       req_any;
  logic       winner;
  logic       in_idle;
  logic       in_data;
  logic       ifu_sel;
  logic       lsu_sel;

  arb_pick u_arb_pick (
    .ifu_req (ifu_arvalid),
    .lsu_req (lsu_arvalid),
    .last    (last_q),
    .req_any (req_any),
    .winner  (winner)
  );

  assign in_idle = (state == ST_IDLE);
  assign in_data = (state == ST_DATA);

  // arready is combinational so the winner sees acceptance in its request cycle
  assign ifu_arready = in_idle && req_any && (winner == GNT_IFU);
  assign lsu_arready = in_idle && req_any && (winner == GNT_LSU);

  assign ifu_sel = in_data && (grant == GNT_IFU);
  assign lsu_sel = in_data && (grant == GNT_LSU);

  assign mem_rready = (ifu_sel && ifu_rready) || (lsu_sel && lsu_rready);

  assign ifu_rvalid = ifu_sel && mem_rvalid;
  assign ifu_rdata  = ifu_sel ? mem_rdata : '0;
  assign ifu_rresp  = ifu_sel ? mem_rresp : 2'b00;

  assign lsu_rvalid = lsu_sel && mem_rvalid;
  assign lsu_rdata  = lsu_sel ? mem_rdata : '0;
  assign lsu_rresp  = lsu_sel ? mem_rresp : 2'b00;

`ifndef ARB_ROUND_ROBIN_EN
  assign last_q = GNT_LSU;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= GNT_IFU;
      mem_arvalid <= 1'b0;
      mem_araddr  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= GNT_LSU;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            grant       <= winner;
            mem_araddr  <= (winner == GNT_LSU) ? lsu_araddr : ifu_araddr;
            mem_arvalid <= 1'b1;
            state       <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_rvalid && mem_rready) begin
            state  <= ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_q <= grant;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [31:0] mem_araddr, mem_rdata;
  logic [1:0]  mem_rresp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rready(mem_rready)
  );

  // advance one clock; inputs are then driven away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_rready = 1'b1;
    lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_rready = 1'b1;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = RESP_OKAY;
    tick(); tick();
    settle();
    n_cmp++; if (mem_arvalid !== 1'b0) begin n_err++; $display("FAIL reset_mem_arvalid got %0h want 0", mem_arvalid); end
    n_cmp++; if (mem_araddr !== 32'h0) begin n_err++; $display("FAIL reset_mem_araddr got %h want 0", mem_araddr); end
    n_cmp++; if ({ifu_arready, lsu_arready} !== 2'b00) begin n_err++; $display("FAIL reset_arready got %b want 00", {ifu_arready, lsu_arready}); end
    n_cmp++; if ({ifu_rvalid, lsu_rvalid, mem_rready} !== 3'b000) begin n_err++; $display("FAIL reset_rvalid_rready got %b want 000", {ifu_rvalid, lsu_rvalid, mem_rready}); end
    n_cmp++; if ({ifu_rdata, lsu_rdata, ifu_rresp, lsu_rresp} !== 68'h0) begin n_err++; $display("FAIL reset_rdata got %h/%h want 0", ifu_rdata, lsu_rdata); end
    rst = 1'b0;
    tick();
  endtask

  // simultaneous requests; expected order depends on the build option
  task automatic test_tie();
    logic        first_lsu;
    logic [31:0] a_first, a_second;
`ifdef ARB_ROUND_ROBIN_EN
    first_lsu = 1'b0; a_first = 32'h8000_0004; a_second = 32'h8000_1000;
`else
    first_lsu = 1'b1; a_first = 32'h8000_1000; a_second = 32'h8000_0004;
`endif
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0004;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1000;
    settle();
    n_cmp++; if ({lsu_arready, ifu_arready} !== {first_lsu, ~first_lsu}) begin n_err++; $display("FAIL tie_first_arready got lsu=%b ifu=%b want lsu=%b", lsu_arready, ifu_arready, first_lsu); end
    tick();
    if (first_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    mem_arready = 1'b1;
    settle();
    n_cmp++; if (mem_arvalid !== 1'b1 || mem_araddr !== a_first) begin n_err++; $display("FAIL tie_first_addr got %b/%h want 1/%h", mem_arvalid, mem_araddr, a_first); end
    n_cmp++; if ({ifu_arready, lsu_arready} !== 2'b00) begin n_err++; $display("FAIL tie_loser_blocked got %b want 00", {ifu_arready, lsu_arready}); end
    tick();
    mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_0001;
    settle();
    if (first_lsu) begin
      n_cmp++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h1111_0001 || ifu_rvalid !== 1'b0) begin n_err++; $display("FAIL tie_first_rdata got lsu %b/%h ifu %b want 1/11110001 0", lsu_rvalid, lsu_rdata, ifu_rvalid); end
    end else begin
      n_cmp++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h1111_0001 || lsu_rvalid !== 1'b0) begin n_err++; $display("FAIL tie_first_rdata got ifu %b/%h lsu %b want 1/11110001 0", ifu_rvalid, ifu_rdata, lsu_rvalid); end
    end
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    settle();
    n_cmp++; if ({lsu_arready, ifu_arready} !== {~first_lsu, first_lsu}) begin n_err++; $display("FAIL tie_second_arready got lsu=%b ifu=%b want lsu=%b", lsu_arready, ifu_arready, ~first_lsu); end
    tick();
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; mem_arready = 1'b1;
    settle();
    n_cmp++; if (mem_araddr !== a_second) begin n_err++; $display("FAIL tie_second_addr got %h want %h", mem_araddr, a_second); end
    tick();
    mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_0002;
    settle();
    if (first_lsu) begin
      n_cmp++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h2222_0002) begin n_err++; $display("FAIL tie_second_rdata got %b/%h want 1/22220002", ifu_rvalid, ifu_rdata); end
    end else begin
      n_cmp++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h2222_0002) begin n_err++; $display("FAIL tie_second_rdata got %b/%h want 1/22220002", lsu_rvalid, lsu_rdata); end
    end
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
  endtask

  task automatic test_ifu_single();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
    settle();
    n_cmp++; if (ifu_arready !== 1'b1 || lsu_arready !== 1'b0) begin n_err++; $display("FAIL ifu_arready got ifu=%b lsu=%b want 1/0", ifu_arready, lsu_arready); end
    n_cmp++; if (mem_arvalid !== 1'b0) begin n_err++; $display("FAIL ifu_arvalid_early got %b want 0", mem_arvalid); end
    tick();
    ifu_arvalid = 1'b0; mem_arready = 1'b1;
    settle();
    n_cmp++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0000) begin n_err++; $display("FAIL ifu_mem_ar got %b/%h want 1/80000000", mem_arvalid, mem_araddr); end
    n_cmp++; if (ifu_arready !== 1'b0 || mem_rready !== 1'b0) begin n_err++; $display("FAIL ifu_addr_phase got arready=%b rready=%b want 0/0", ifu_arready, mem_rready); end
    tick();
    mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413; mem_rresp = RESP_OKAY;
    settle();
    n_cmp++; if (mem_arvalid !== 1'b0) begin n_err++; $display("FAIL ifu_arvalid_clear got %b want 0", mem_arvalid); end
    n_cmp++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || ifu_rresp !== 2'b00) begin n_err++; $display("FAIL ifu_rdata got %b/%h/%b want 1/00000413/00", ifu_rvalid, ifu_rdata, ifu_rresp); end
    n_cmp++; if (mem_rready !== 1'b1) begin n_err++; $display("FAIL ifu_mem_rready got %b want 1", mem_rready); end
    n_cmp++; if (lsu_rvalid !== 1'b0 || lsu_rdata !== 32'h0) begin n_err++; $display("FAIL ifu_lsu_quiet got %b/%h want 0/0", lsu_rvalid, lsu_rdata); end
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    settle();
    n_cmp++; if (ifu_rvalid !== 1'b0 || mem_rready !== 1'b0) begin n_err++; $display("FAIL ifu_done got rvalid=%b rready=%b want 0/0", ifu_rvalid, mem_rready); end
    tick();
  endtask

  task automatic test_arready_delay();
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000;
    settle();
    n_cmp++; if (lsu_arready !== 1'b1) begin n_err++; $display("FAIL delay_accept got %b want 1", lsu_arready); end
    tick();
    lsu_arvalid = 1'b0; ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0010;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_cmp++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_2000) begin n_err++; $display("FAIL delay_hold_%0d got %b/%h want 1/80002000", i, mem_arvalid, mem_araddr); end
      n_cmp++; if ({ifu_arready, lsu_arready} !== 2'b00) begin n_err++; $display("FAIL delay_no_arready_%0d got %b want 00", i, {ifu_arready, lsu_arready}); end
      n_cmp++; if (mem_rready !== 1'b0 || lsu_rvalid !== 1'b0) begin n_err++; $display("FAIL delay_stray_rvalid_%0d got rready=%b rvalid=%b want 0/0", i, mem_rready, lsu_rvalid); end
      tick();
    end
    mem_rvalid = 1'b0; mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_0003; ifu_arvalid = 1'b0;
    settle();
    n_cmp++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h3333_0003) begin n_err++; $display("FAIL delay_rdata got %b/%h want 1/33330003", lsu_rvalid, lsu_rdata); end
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
  endtask

  task automatic test_rready_backpressure();
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_3000;
    settle();
    tick();
    lsu_arvalid = 1'b0; mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h4444_0004; lsu_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if (mem_rready !== 1'b0) begin n_err++; $display("FAIL bp_rready_%0d got %b want 0", i, mem_rready); end
      n_cmp++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h4444_0004) begin n_err++; $display("FAIL bp_hold_%0d got %b/%h want 1/44440004", i, lsu_rvalid, lsu_rdata); end
      tick();
    end
    lsu_rready = 1'b1;
    settle();
    n_cmp++; if (mem_rready !== 1'b1) begin n_err++; $display("FAIL bp_release got %b want 1", mem_rready); end
    tick();
    settle();
    n_cmp++; if (lsu_rvalid !== 1'b0 || mem_rready !== 1'b0) begin n_err++; $display("FAIL bp_done got rvalid=%b rready=%b want 0/0", lsu_rvalid, mem_rready); end
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
  endtask

  task automatic test_slverr();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0020;
    settle();
    tick();
    ifu_arvalid = 1'b0; mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_0005; mem_rresp = RESP_SLVERR;
    settle();
    n_cmp++; if (ifu_rvalid !== 1'b1 || ifu_rresp !== 2'b10) begin n_err++; $display("FAIL slverr_resp got %b/%b want 1/10", ifu_rvalid, ifu_rresp); end
    n_cmp++; if (lsu_rresp !== 2'b00) begin n_err++; $display("FAIL slverr_lsu_resp got %b want 00", lsu_rresp); end
    tick();
    settle();
    n_cmp++; if (ifu_rvalid !== 1'b0 || mem_rready !== 1'b0 || ifu_rresp !== 2'b00) begin n_err++; $display("FAIL slverr_idle got rvalid=%b rready=%b rresp=%b want 0/0/00", ifu_rvalid, mem_rready, ifu_rresp); end
    mem_rvalid = 1'b0; mem_rresp = RESP_OKAY; mem_rdata = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_4000;
    settle();
    tick();
    ifu_arvalid = 1'b0;
    settle();
    n_cmp++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_4000) begin n_err++; $display("FAIL rstmid_addr got %b/%h want 1/80004000", mem_arvalid, mem_araddr); end
    rst = 1'b1;
    tick();
    settle();
    n_cmp++; if (mem_arvalid !== 1'b0 || mem_araddr !== 32'h0) begin n_err++; $display("FAIL rstmid_clear got %b/%h want 0/0", mem_arvalid, mem_araddr); end
    rst = 1'b0;
    tick();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0008;
    settle();
    n_cmp++; if (ifu_arready !== 1'b1) begin n_err++; $display("FAIL rstmid_fresh_arready got %b want 1", ifu_arready); end
    tick();
    ifu_arvalid = 1'b0; mem_arready = 1'b1;
    settle();
    n_cmp++; if (mem_araddr !== 32'h8000_0008) begin n_err++; $display("FAIL rstmid_fresh_addr got %h want 80000008", mem_araddr); end
    tick();
    mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    n_cmp++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rstmid_fresh_rdata got %b/%h want 1/deadbeef", ifu_rvalid, ifu_rdata); end
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_ifu_single();
    test_arready_delay();
    test_rready_backpressure();
    test_slverr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares the single AXI-lite read port of data memory between the instruction fetch unit (IFU) and the load path of the write-back/LSU stage. Each request is granted whole, one transaction outstanding at a time. The granted master's address is registered onto the memory AR channel, and the R response is routed back to the same master. It sits between IFU/WBU and the memory model; the write channels bypass this block.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read data width

Ports (name direction width meaning):
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ifu_arvalid / ifu_araddr  in  1 / ADDR_W  IFU read request
- ifu_arready  out  1  IFU address accepted
- ifu_rvalid / ifu_rdata / ifu_rresp  out  1 / DATA_W / 2  IFU response
- ifu_rready  in  1  IFU accepts response
- lsu_arvalid / lsu_araddr  in  1 / ADDR_W  LSU read request
- lsu_arready  out  1  LSU address accepted
- lsu_rvalid / lsu_rdata / lsu_rresp  out  1 / DATA_W / 2  LSU response
- lsu_rready  in  1  LSU accepts response
- mem_arvalid / mem_araddr  out  1 / ADDR_W  registered request to memory
- mem_arready  in  1  memory accepts address
- mem_rvalid / mem_rdata / mem_rresp  in  1 / DATA_W / 2  memory response
- mem_rready  out  1  forwarded rready of granted master

## Operation
- States: IDLE, ADDR, DATA. Encoding is 2 bits.
- IDLE: the arbiter picks a winner among asserted arvalid. It asserts the winner's arready combinationally in the same cycle, latches the winner into `grant` (1 bit, 0=IFU, 1=LSU) and the winner's araddr into mem_araddr, sets mem_arvalid, and goes to ADDR. With no request it stays in IDLE.
- ADDR: mem_arvalid is held high and mem_araddr is stable. On mem_arready it clears mem_arvalid and goes to DATA.
- DATA: routing follows `grant`:
  - mem_rready = rready of the granted master.
  - Granted master's rvalid/rdata/rresp = mem_rvalid/mem_rdata/mem_rresp.
  - On mem_rvalid && mem_rready the arbiter goes to IDLE. In the round-robin build it also updates `last`.
- Non-granted master, or any state other than DATA: rvalid=0, rdata=0, rresp=0. mem_rready=0 outside DATA.
- arready is never asserted outside IDLE. A losing master keeps arvalid high, per AXI rules, and is served later.
- rresp is passed through unmodified. The arbiter does not interpret errors.
- The arbiter never reorders or merges transactions. At most one transaction is outstanding.

## Timing
- Reset values: state=IDLE, grant=0, last=1, mem_arvalid=0, mem_araddr=0. All arready/rvalid/rdata/rresp outputs and mem_rready are 0.
- Request accepted in cycle N → mem_arvalid high from N+1.
- mem_arready in cycle M → R routing active from M+1.
- R handshake in cycle K → IDLE in K+1, next grant possible in K+1. Back-to-back requests cost 1 idle cycle.
- Minimum request-to-response: 3 cycles with a zero-wait memory.
- Simultaneous ifu_arvalid and lsu_arvalid in IDLE: resolved per Configuration. The loser sees arready=0.
- mem_rvalid arriving in ADDR (protocol violation) is ignored: mem_rready is 0.
- rst asserted mid-transaction: all outputs return to reset values the next cycle and the in-flight transaction is abandoned. The memory slave must share rst.

## Configuration
- ARB_ROUND_ROBIN_EN defined: 1-bit `last` register, updated on each completed R handshake. On a tie, the master not in `last` wins. After reset IFU wins the first tie.
- Undefined: fixed priority, LSU always beats IFU. There is no `last` register, so the reset value of `last` does not apply.

## Structure
- Shared package holds `arb_state_t` (IDLE/ADDR/DATA), the grant encodings `GNT_IFU=1'b0` and `GNT_LSU=1'b1`, and the AXI resp constants `RESP_OKAY=2'b00` and `RESP_SLVERR=2'b10`.
- One sub-module, `arb_pick`: combinational winner selection from {ifu_arvalid, lsu_arvalid, last}. It holds the macro-dependent logic. The FSM and muxes stay in mem_read_arbiter.

## Test plan
- IFU only, araddr=0x8000_0000, memory 0-wait, rdata=0x0000_0413 → ifu_arready pulses cycle N, mem_araddr=0x8000_0000 from N+1, ifu_rdata=0x0000_0413 with rresp=0, lsu_rvalid stays 0.
- Both request same cycle, IFU 0x8000_0004 and LSU 0x8000_1000:
  - Fixed priority: LSU served first, then IFU, with 1 idle cycle between.
  - ARB_ROUND_ROBIN_EN: IFU first, then LSU.
- mem_arready delayed 5 cycles → mem_arvalid and mem_araddr held stable all 5 cycles, no second arready to either master.
- Granted LSU holds lsu_rready=0 for 3 cycles while mem_rvalid=1 → mem_rready=0, no state change; completes on the first lsu_rready=1.
- mem_rresp=2'b10 on an IFU read → ifu_rresp=2'b10 delivered unmodified, arbiter returns to IDLE.
- rst asserted in ADDR state → next cycle mem_arvalid=0, mem_araddr=0, state IDLE. After rst deasserts, a fresh IFU request completes normally.
